// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light controller: state encoding,
// {R,Y,G} lamp codes, default intervals and the state-to-lamp mapping.
package traffic_pkg;

  localparam int unsigned TBASE_DEF = 6;  // base green interval, seconds
  localparam int unsigned TEXT_DEF  = 3;  // extension / walk interval, seconds
  localparam int unsigned TYEL_DEF  = 2;  // yellow interval, seconds

  typedef enum logic [2:0] {
    MAIN_GRN = 3'd0,
    MAIN_YEL = 3'd1,
    WALK     = 3'd2,
    SIDE_GRN = 3'd3,
    SIDE_YEL = 3'd4
  } state_t;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  typedef struct packed {
    logic [2:0] main;
    logic [2:0] side;
    logic       walk;
  } lamps_t;

  function automatic lamps_t lamps_of(input state_t s);
    lamps_t l;
    l = '{main: LAMP_R, side: LAMP_R, walk: 1'b0};
    case (s)
      MAIN_GRN: l.main = LAMP_G;
      MAIN_YEL: l.main = LAMP_Y;
      WALK:     l.walk = 1'b1;
      SIDE_GRN: l.side = LAMP_G;
      SIDE_YEL: l.side = LAMP_Y;
      default:  l = '{main: LAMP_R, side: LAMP_R, walk: 1'b0};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/sec_timer.sv
// Seconds counter: advances on each one-second tick, cleared on demand.
module sec_timer
  import traffic_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         OneHz_En,
  input  logic         Clear,
  output logic [W-1:0] Count
);

  logic [W-1:0] r_count;

  // Clear has priority so a transition on a tick edge restarts at zero.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)      r_count <= '0;
    else if (Clear)    r_count <= '0;
    else if (OneHz_En) r_count <= r_count + W'(1);
  end

  assign Count = r_count;

endmodule

// File: rtl/traffic_fsm.sv
// Traffic-light controller: main/side street lamps with pedestrian walk
// phase, sensor-driven green extension and registered lamp outputs.
module traffic_fsm
  import traffic_pkg::*;
#(
  parameter int unsigned TBASE = TBASE_DEF,
  parameter int unsigned TEXT  = TEXT_DEF,
  parameter int unsigned TYEL  = TYEL_DEF
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       OneHz_En,
  input  logic       Sensor,
  input  logic       WalkReq,
  output logic       WalkReg_Reset,
  output logic [2:0] Main_RYG,
  output logic [2:0] Side_RYG,
  output logic       Walk_Light
);

  localparam int unsigned CW = $clog2(2 * TBASE + 1);

  localparam logic [CW-1:0] C_MG_EXT = CW'(TBASE + TEXT - 1);
  localparam logic [CW-1:0] C_MG_MAX = CW'(2 * TBASE - 1);
  localparam logic [CW-1:0] C_YEL    = CW'(TYEL - 1);
  localparam logic [CW-1:0] C_WALK   = CW'(TEXT - 1);
  localparam logic [CW-1:0] C_SG_MIN = CW'(TBASE - 1);
  localparam logic [CW-1:0] C_SG_MAX = CW'(TBASE + TEXT - 1);

  state_t        r_state;
  state_t        w_next;
  logic          w_clear;
  logic [CW-1:0] w_count;
  lamps_t        w_lamps;
  logic          w_wrr;

  logic [2:0]    r_main;
  logic [2:0]    r_side;
  logic          r_walk;
  logic          r_wrr;

  sec_timer #(.W(CW)) u_timer (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .OneHz_En (OneHz_En),
    .Clear    (w_clear),
    .Count    (w_count)
  );

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= MAIN_GRN;
    else          r_state <= w_next;
  end

  // Next-state: terminal-count compares, qualified by the tick; inputs are
  // sampled only at the exit decision points.
  always_comb begin
    w_next = r_state;
    case (r_state)
      MAIN_GRN:
        if (OneHz_En && ((w_count == C_MG_EXT && Sensor) || w_count == C_MG_MAX))
          w_next = MAIN_YEL;
      MAIN_YEL:
        if (OneHz_En && w_count == C_YEL)
          w_next = WalkReq ? WALK : SIDE_GRN;
      WALK:
        if (OneHz_En && w_count == C_WALK)
          w_next = SIDE_GRN;
      SIDE_GRN:
        if (OneHz_En && ((w_count == C_SG_MIN && !Sensor) || w_count == C_SG_MAX))
          w_next = SIDE_YEL;
      SIDE_YEL:
        if (OneHz_En && w_count == C_YEL)
          w_next = MAIN_GRN;
      default:
        w_next = MAIN_GRN;
    endcase
    w_clear = (w_next != r_state);
  end

  // Output decode from the next state, so the registered lamps line up
  // with the state register rather than trailing it by a cycle.
  always_comb begin
    w_lamps = lamps_of(w_next);
    w_wrr   = (w_next == WALK) && (r_state != WALK);
  end

  // Output registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_main <= LAMP_G;
      r_side <= LAMP_R;
      r_walk <= 1'b0;
      r_wrr  <= 1'b0;
    end else begin
      r_main <= w_lamps.main;
      r_side <= w_lamps.side;
      r_walk <= w_lamps.walk;
      r_wrr  <= w_wrr;
    end
  end

  assign Main_RYG      = r_main;
  assign Side_RYG      = r_side;
  assign Walk_Light    = r_walk;
  assign WalkReg_Reset = r_wrr;

endmodule

// File: tb/tb_traffic_fsm.sv
// Directed testbench for traffic_fsm with defaults TBASE=6, TEXT=3, TYEL=2.
module tb_traffic_fsm;

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       OneHz_En;
  logic       Sensor;
  logic       WalkReq;
  logic       WalkReg_Reset;
  logic [2:0] Main_RYG;
  logic [2:0] Side_RYG;
  logic       Walk_Light;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int unsigned n_fail  = 0;
  int unsigned pulse_cnt = 0;
  int unsigned inv_err   = 0;
  logic        chk_en    = 1'b0;
  int unsigned p0;

  always #5 Clk = ~Clk;

  traffic_fsm #(.TBASE(6), .TEXT(3), .TYEL(2)) dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .OneHz_En      (OneHz_En),
    .Sensor        (Sensor),
    .WalkReq       (WalkReq),
    .WalkReg_Reset (WalkReg_Reset),
    .Main_RYG      (Main_RYG),
    .Side_RYG      (Side_RYG),
    .Walk_Light    (Walk_Light)
  );

  // Count cycles in which WalkReg_Reset was high (value held before each edge).
  always @(posedge Clk) begin
    if (WalkReg_Reset === 1'b1) pulse_cnt++;
  end

  // Lamp invariants every cycle: one-hot, never both streets non-red.
  always @(negedge Clk) begin
    if (chk_en) begin
      if (!$onehot(Main_RYG) || !$onehot(Side_RYG) ||
          (Main_RYG !== R && Side_RYG !== R)) begin
        inv_err++;
        $display("FAIL lamp_invariant @%0t: main=%b side=%b", $time, Main_RYG, Side_RYG);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, observed no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    repeat (9) @(negedge Clk);
    OneHz_En = 1'b1;
    @(negedge Clk);
    OneHz_En = 1'b0;
  endtask

  // Check the lamps at entry and after each of the first n-1 ticks, then
  // apply the n-th tick, which must leave the state.
  task automatic run_state(input string tag, input int unsigned n,
                           input logic [2:0] m, input logic [2:0] s, input logic w);
    for (int unsigned i = 0; i < n; i++) begin
      chk($sformatf("%s_main_t%0d", tag, i), {5'd0, Main_RYG}, {5'd0, m});
      chk($sformatf("%s_side_t%0d", tag, i), {5'd0, Side_RYG}, {5'd0, s});
      chk($sformatf("%s_walk_t%0d", tag, i), {7'd0, Walk_Light}, {7'd0, w});
      tick();
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_main"}, {5'd0, Main_RYG}, {5'd0, G});
    chk({tag, "_side"}, {5'd0, Side_RYG}, {5'd0, R});
    chk({tag, "_walk"}, {7'd0, Walk_Light}, 8'd0);
    chk({tag, "_wrr"},  {7'd0, WalkReg_Reset}, 8'd0);
  endtask

  initial begin
    Reset_n  = 1'b0;
    OneHz_En = 1'b0;
    Sensor   = 1'b0;
    WalkReq  = 1'b0;
    repeat (3) @(negedge Clk);
    chk_reset_outputs("rst");
    chk_en  = 1'b1;
    Reset_n = 1'b1;

    // Nominal cycle, no sensor, no walk request.
    run_state("mg",  12, G, R, 1'b0);
    run_state("my",   2, Y, R, 1'b0);
    run_state("sg",   6, R, G, 1'b0);
    run_state("sy",   2, R, Y, 1'b0);

    // Sensor held high: both greens extended to 9 ticks.
    Sensor = 1'b1;
    run_state("mgS",  9, G, R, 1'b0);
    run_state("myS",  2, Y, R, 1'b0);
    run_state("sgS",  9, R, G, 1'b0);
    run_state("syS",  2, R, Y, 1'b0);
    Sensor = 1'b0;

    // Walk request during main green.
    p0 = pulse_cnt;
    WalkReq = 1'b1;
    run_state("mgW",  12, G, R, 1'b0);
    run_state("myW",   2, Y, R, 1'b0);
    chk("walk1_pulse_hi", {7'd0, WalkReg_Reset}, 8'd1);
    WalkReq = 1'b0;                 // walk register cleared by the pulse
    @(negedge Clk);
    chk("walk1_pulse_lo", {7'd0, WalkReg_Reset}, 8'd0);
    WalkReq = 1'b1;                 // new request arrives during WALK
    run_state("walk1", 3, R, R, 1'b1);
    chk("walk1_npulse", 8'(pulse_cnt - p0), 8'd1);
    run_state("sgW",   6, R, G, 1'b0);
    run_state("syW",   2, R, Y, 1'b0);
    run_state("mgW2", 12, G, R, 1'b0);
    run_state("myW2",  2, Y, R, 1'b0);
    chk("walk2_pulse_hi", {7'd0, WalkReg_Reset}, 8'd1);
    chk("walk2_lamp", {7'd0, Walk_Light}, 8'd1);
    WalkReq = 1'b0;
    @(negedge Clk);
    chk("walk2_pulse_lo", {7'd0, WalkReg_Reset}, 8'd0);
    tick();
    chk("walk2_mid_walk", {7'd0, Walk_Light}, 8'd1);
    chk("walk2_mid_main", {5'd0, Main_RYG}, {5'd0, R});

    // Reset in the middle of WALK.
    @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    repeat (3) @(negedge Clk);
    chk_reset_outputs("midrst_hold");
    Reset_n = 1'b1;
    run_state("mgR",  12, G, R, 1'b0);
    run_state("myR",   2, Y, R, 1'b0);
    chk("post_rst_sg_main", {5'd0, Main_RYG}, {5'd0, R});
    chk("post_rst_sg_side", {5'd0, Side_RYG}, {5'd0, G});
    chk("total_pulses", 8'(pulse_cnt - p0), 8'd2);
    chk("lamp_invariant_errs", 8'(inv_err), 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/traffic_fsm.md
TRAFFIC_FSM -- requirements
Module: traffic_fsm

Interface
REQ-001 Parameter TBASE, default 6: base green interval, in seconds.
REQ-002 Parameter TEXT, default 3: extension and walk interval, in seconds.
REQ-003 Parameter TYEL, default 2: yellow interval, in seconds.
REQ-004 Clk  in  1  single system clock; all state changes on its rising edge.
REQ-005 Reset_n  in  1  asynchronous, active-low reset.
REQ-006 OneHz_En  in  1  one-Clk-wide tick, one per second, already synchronous to Clk.
REQ-007 Sensor  in  1  synchronized side-street vehicle sensor, level.
REQ-008 WalkReq  in  1  latched pedestrian request from the walk register, level.
REQ-009 WalkReg_Reset  out  1  one-Clk pulse that clears the walk register.
REQ-010 Main_RYG  out  3  main-street lamps {R,Y,G}, one-hot.
REQ-011 Side_RYG  out  3  side-street lamps {R,Y,G}, one-hot.
REQ-012 Walk_Light  out  1  pedestrian walk lamp.

Function
REQ-013 States SHALL be: MAIN_GRN, MAIN_YEL, WALK, SIDE_GRN, SIDE_YEL.
REQ-014 Lamps SHALL be a registered function of the state: MAIN_GRN Main=G, Side=R; MAIN_YEL Main=Y, Side=R; WALK Main=R, Side=R, Walk_Light=1; SIDE_GRN Main=R, Side=G; SIDE_YEL Main=R, Side=Y.
REQ-015 Walk_Light SHALL be 1 only in WALK.
REQ-016 A seconds counter SHALL increment only on Clk edges with OneHz_En=1, and SHALL clear to 0 on every state transition.
REQ-017 A condition "count==N-1 at a OneHz_En edge" SHALL cause the transition on that same edge, so each state lasts exactly N ticks after entry.
REQ-018 MAIN_GRN SHALL exit on tick TBASE+TEXT when Sensor=1 at that tick, and otherwise SHALL exit on tick 2*TBASE.
REQ-019 MAIN_YEL SHALL exit after TYEL ticks, to WALK if WalkReq=1 on the exit edge and to SIDE_GRN otherwise.
REQ-020 WALK SHALL last TEXT ticks, then go to SIDE_GRN.
REQ-021 SIDE_GRN SHALL exit on tick TBASE when Sensor=0 at that tick, and otherwise on tick TBASE+TEXT.
REQ-022 SIDE_YEL SHALL last TYEL ticks, then go to MAIN_GRN.
REQ-023 WalkReg_Reset SHALL be high for exactly the first Clk cycle in which the state is WALK, and low at all other times.
REQ-024 A WalkReq that rises during WALK or later SHALL NOT be cleared; it SHALL be serviced at the next MAIN_YEL exit.
REQ-025 WalkReq and Sensor SHALL be ignored at all edges other than those named in REQ-018, REQ-019 and REQ-021.
REQ-026 The counter width SHALL be ceil(log2(2*TBASE+1)) bits; the counter SHALL never wrap within a state.
REQ-027 Illegal state encodings SHALL recover to MAIN_GRN on the next edge.

Reset
REQ-028 While Reset_n=0, the block SHALL be asynchronously in this state: state MAIN_GRN, counter 0, Main_RYG=001, Side_RYG=100, Walk_Light=0, WalkReg_Reset=0.
REQ-029 On deassertion of Reset_n, timing SHALL restart with a full MAIN_GRN interval.
REQ-030 Reset asserted mid-operation, including during WALK, SHALL abort the current state with no WalkReg_Reset pulse.

Structure
REQ-031 State encoding, lamp constants ({R,Y,G} codes) and the default intervals SHALL reside in a shared package, traffic_pkg.
REQ-032 The seconds counter SHALL be one sub-module, sec_timer, with inputs Clk, Reset_n, OneHz_En and Clear, and output Count.
REQ-033 The FSM, the output registers and the terminal-count compare SHALL reside in traffic_fsm.

Verification
REQ-034 Reset, then Sensor=0 and WalkReq=0, with ticks every 10 Clk -> MAIN_GRN holds 12 ticks, MAIN_YEL 2, SIDE_GRN 6, SIDE_YEL 2, then back to MAIN_GRN.
REQ-035 Sensor=1 throughout -> MAIN_GRN holds 9 ticks and SIDE_GRN holds 9 ticks.
REQ-036 WalkReq=1 during MAIN_GRN -> after MAIN_YEL, WALK holds 3 ticks with Walk_Light=1 and Main=Side=100; WalkReg_Reset is high exactly 1 Clk, then SIDE_GRN follows.
REQ-037 WalkReq rising during WALK -> no second pulse in that WALK; WALK is re-entered in the next cycle with exactly 1 pulse.
REQ-038 Reset_n pulled low for 3 Clk in the middle of WALK -> outputs match REQ-028 immediately, there is no pulse, and the MAIN_GRN interval is a full 12 ticks.
REQ-039 A checker asserts in every scenario: the lamp outputs are always one-hot, and Main and Side are never non-red simultaneously.
